// File: rtl/fp_to_int_sched.sv
// Two-port round-robin scheduler around a combinational fp32-to-integer converter.
// One operand register (S1) in front of the converter, one result register (OUT) behind it.
module fp_to_int_sched #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [31:0]      io_in_0_bits_a,
  input  logic [2:0]       io_in_0_bits_rm,
  input  logic [1:0]       io_in_0_bits_op,
  input  logic [TAG_W-1:0] io_in_0_bits_tag,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [31:0]      io_in_1_bits_a,
  input  logic [2:0]       io_in_1_bits_rm,
  input  logic [1:0]       io_in_1_bits_op,
  input  logic [TAG_W-1:0] io_in_1_bits_tag,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [63:0]      io_out_bits_result,
  output logic [4:0]       io_out_bits_fflags,
  output logic [TAG_W-1:0] io_out_bits_tag,
  output logic             io_out_bits_src,
  output logic             io_busy
);

  // Returns {result[63:0], fflags{NV,DZ,OF,UF,NX}}; op: 0=W 1=WU 2=L 3=LU.
  function automatic logic [68:0] fp_to_int(input logic [31:0] a, input logic [2:0] rm,
                                            input logic [1:0] op);
    logic        sign, is_nan, big, is32, uns, g, s, inc, ovf, pos, nv, nx;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [127:0] fixed;
    logic [63:0] ipart, val, res;
    logic [64:0] mag;
    sign   = a[31];
    exp    = a[30:23];
    mant   = {|exp, a[22:0]};
    is_nan = (exp == 8'hff) && (|a[22:0]);
    big    = (exp >= 8'd191);
    is32   = !op[1];
    uns    = op[0];
    // 64.64 fixed point; anything below 2^-40 only contributes sticky
    fixed = '0;
    if (exp < 8'd86) begin
      fixed[0] = |mant;
    end else if (!big) begin
      fixed = {104'b0, mant} << (exp - 8'd86);
    end
    ipart = fixed[127:64];
    g     = fixed[63];
    s     = |fixed[62:0];
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (g | s);
      3'd3:    inc = !sign & (g | s);
      3'd4:    inc = g;
      default: inc = g & (s | ipart[0]);
    endcase
    mag = {1'b0, ipart} + 65'(inc);
    if (uns) begin
      ovf = sign ? (mag != '0) : (is32 ? (|mag[64:32]) : mag[64]);
    end else if (is32) begin
      ovf = sign ? (mag > 65'h80000000) : (mag > 65'h7fffffff);
    end else begin
      ovf = sign ? (mag > 65'h8000000000000000) : (mag > 65'h7fffffffffffffff);
    end
    ovf = ovf | big;
    val = sign ? (64'd0 - mag[63:0]) : mag[63:0];
    pos = is_nan | !sign;
    if (ovf) begin
      nv = 1'b1;
      nx = 1'b0;
      if (uns)       res = pos ? '1 : '0;
      else if (is32) res = pos ? 64'h000000007fffffff : 64'hffffffff80000000;
      else           res = pos ? 64'h7fffffffffffffff : 64'h8000000000000000;
    end else begin
      nv  = 1'b0;
      nx  = g | s;
      res = is32 ? {{32{val[31]}}, val[31:0]} : val;
    end
    return {res, nv, 3'b000, nx};
  endfunction

  logic             s1_valid_q, s1_src_q, out_valid_q, out_src_q, prio_q;
  logic [31:0]      s1_a_q;
  logic [2:0]       s1_rm_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q, out_tag_q;
  logic [63:0]      out_result_q;
  logic [4:0]       out_fflags_q;
  logic             out_free, s1_adv, s1_free, grant_valid, grant;
  logic [68:0]      conv;

  assign conv     = fp_to_int(s1_a_q, s1_rm_q, s1_op_q);
  assign out_free = !out_valid_q | io_out_ready;
  assign s1_adv   = s1_valid_q & out_free;
  assign s1_free  = !s1_valid_q | s1_adv;

  always_comb begin
    grant_valid = 1'b0;
    grant       = prio_q;
    if (s1_free && !io_flush) begin
      if (prio_q ? io_in_1_valid : io_in_0_valid) begin
        grant_valid = 1'b1;
        grant       = prio_q;
      end else if (prio_q ? io_in_0_valid : io_in_1_valid) begin
        grant_valid = 1'b1;
        grant       = ~prio_q;
      end
    end
  end

  assign io_in_0_ready = grant_valid & ~grant;
  assign io_in_1_ready = grant_valid & grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_rm_q      <= '0;
      s1_op_q      <= '0;
      s1_tag_q     <= '0;
      s1_src_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_fflags_q <= '0;
      out_tag_q    <= '0;
      out_src_q    <= 1'b0;
      prio_q       <= 1'b0;
    end else if (io_flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid_q  <= 1'b1;
        out_result_q <= conv[68:5];
        out_fflags_q <= conv[4:0];
        out_tag_q    <= s1_tag_q;
        out_src_q    <= s1_src_q;
      end else if (io_out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (grant_valid) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= grant ? io_in_1_bits_a : io_in_0_bits_a;
        s1_rm_q    <= grant ? io_in_1_bits_rm : io_in_0_bits_rm;
        s1_op_q    <= grant ? io_in_1_bits_op : io_in_0_bits_op;
        s1_tag_q   <= grant ? io_in_1_bits_tag : io_in_0_bits_tag;
        s1_src_q   <= grant;
        prio_q     <= ~grant;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign io_out_valid       = out_valid_q;
  assign io_out_bits_result = out_result_q;
  assign io_out_bits_fflags = out_fflags_q;
  assign io_out_bits_tag    = out_tag_q;
  assign io_out_bits_src    = out_src_q;
  assign io_busy            = s1_valid_q | out_valid_q;

endmodule
